// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline types and constants for the fetch front end
package fetch_unit_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_e;

  localparam word_t      NOP_INSTR_DEF  = 16'h0000;
  localparam logic [3:0] HLT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/fetch_fsm.sv
// rtl/fetch_fsm.sv - fetch state register with next-state, enable and strobe logic
module fetch_fsm
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic         imem_ready,
  input  logic         is_hlt,
  output fetch_state_e state,
  output logic         deliver,
  output logic         redir_take,
  output logic         pc_we,
  output logic         req_we,
  output logic         imem_req,
  output logic         fd_enable,
  output logic         halted
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         active;

  always_comb begin
    state_d    = state_q;
    redir_take = redirect && !stall && (state_q != ST_HALT);
    active     = (state_q == ST_RUN) || (state_q == ST_MISS);
    deliver    = active && imem_ready && !redir_take;
    pc_we      = redir_take || (deliver && !stall);
    req_we     = (state_q == ST_RUN);

    case (state_q)
      ST_RUN, ST_MISS: begin
        // A redirect on an unanswered request must wait out that request in SQUASH.
        if (redir_take) begin
          state_d = imem_ready ? ST_RUN : ST_SQUASH;
        end else if (deliver && !stall) begin
          state_d = is_hlt ? ST_HALT : ST_RUN;
        end else if (!imem_ready && !stall) begin
          state_d = ST_MISS;
        end
      end
      ST_SQUASH: begin
        if (imem_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state     = state_q;
  assign imem_req  = !rst && (state_q != ST_HALT);
  assign fd_enable = !rst && !stall;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: rtl/register.sv
// rtl/register.sv - write-enabled register with asynchronous active-high reset
module register #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipeline front end: PC, instruction requests and fetch/decode write side
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t      RESET_PC   = 16'h0000,
  parameter word_t      NOP_INSTR  = NOP_INSTR_DEF,
  parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] fd_pc,
  output logic [15:0] fd_instr,
  output logic        fd_enable,
  output logic        halted
);

  fetch_state_e state;
  logic         deliver;
  logic         redir_take;
  logic         pc_we;
  logic         req_we;
  logic         is_hlt;
  word_t        pc_q;
  word_t        pc_d;
  word_t        req_addr_q;
  word_t        req_addr_d;
  word_t        cur_addr;
  word_t        seq_pc;

  fetch_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .imem_ready (imem_ready),
    .is_hlt     (is_hlt),
    .state      (state),
    .deliver    (deliver),
    .redir_take (redir_take),
    .pc_we      (pc_we),
    .req_we     (req_we),
    .imem_req   (imem_req),
    .fd_enable  (fd_enable),
    .halted     (halted)
  );

  register #(.WIDTH(WORD_W), .RESET_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .we  (pc_we),
    .d   (pc_d),
    .q   (pc_q)
  );

  register #(.WIDTH(WORD_W), .RESET_VAL(RESET_PC)) u_req_addr (
    .clk (clk),
    .rst (rst),
    .we  (req_we),
    .d   (req_addr_d),
    .q   (req_addr_q)
  );

  // In RUN the request goes out from pc this cycle; otherwise the held address is reissued.
  always_comb begin
    cur_addr   = (state == ST_RUN) ? pc_q : req_addr_q;
    seq_pc     = cur_addr + 16'd2;
    is_hlt     = (imem_data[15:12] == HLT_OPCODE);
    pc_d       = redir_take ? redirect_pc : seq_pc;
    req_addr_d = pc_q;
    imem_addr  = cur_addr;
    fd_instr   = deliver ? imem_data : NOP_INSTR;
    fd_pc      = deliver ? seq_pc : (pc_q + 16'd2);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] fd_pc;
  logic [15:0] fd_instr;
  logic        fd_enable;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .fd_pc       (fd_pc),
    .fd_instr    (fd_instr),
    .fd_enable   (fd_enable),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
  task automatic drive(input logic s, input logic r, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] data);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_data   = data;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("rst_imem_req", {15'd0, imem_req}, 16'd0);
    chk("rst_fd_enable", {15'd0, fd_enable}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    tick();
    rst = 1'b0;

    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk("hit0_addr", imem_addr, 16'h0000);
    chk("hit0_req", {15'd0, imem_req}, 16'd1);
    chk("hit0_instr", fd_instr, 16'h1234);
    chk("hit0_pc", fd_pc, 16'h0002);
    chk("hit0_en", {15'd0, fd_enable}, 16'd1);
    chk("hit0_halted", {15'd0, halted}, 16'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2345);
    chk("hit1_addr", imem_addr, 16'h0002);
    chk("hit1_instr", fd_instr, 16'h2345);
    chk("hit1_pc", fd_pc, 16'h0004);
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
      chk($sformatf("miss%0d_addr", i), imem_addr, 16'h0004);
      chk($sformatf("miss%0d_instr", i), fd_instr, 16'h0000);
      chk($sformatf("miss%0d_en", i), {15'd0, fd_enable}, 16'd1);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3456);
    chk("fill_addr", imem_addr, 16'h0004);
    chk("fill_instr", fd_instr, 16'h3456);
    chk("fill_pc", fd_pc, 16'h0006);
    tick();

    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4567);
      chk($sformatf("stall%0d_addr", i), imem_addr, 16'h0006);
      chk($sformatf("stall%0d_en", i), {15'd0, fd_enable}, 16'd0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4567);
    chk("unstall_addr", imem_addr, 16'h0006);
    chk("unstall_instr", fd_instr, 16'h4567);
    chk("unstall_pc", fd_pc, 16'h0008);
    tick();

    drive(1'b1, 1'b1, 16'h0200, 1'b1, 16'h5678);
    chk("stallredir_en", {15'd0, fd_enable}, 16'd0);
    chk("stallredir_addr", imem_addr, 16'h0008);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678);
    chk("ignored_addr", imem_addr, 16'h0008);
    chk("ignored_instr", fd_instr, 16'h5678);
    chk("ignored_pc", fd_pc, 16'h000A);
    tick();

    drive(1'b0, 1'b1, 16'h0100, 1'b1, 16'h7777);
    chk("redir_addr", imem_addr, 16'h000A);
    chk("redir_instr", fd_instr, 16'h0000);
    chk("redir_en", {15'd0, fd_enable}, 16'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6789);
    chk("tgt_addr", imem_addr, 16'h0100);
    chk("tgt_instr", fd_instr, 16'h6789);
    chk("tgt_pc", fd_pc, 16'h0102);
    tick();

    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'hAAAA);
    chk("mredir0_addr", imem_addr, 16'h0102);
    tick();
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'hAAAA);
    chk("mredir1_addr", imem_addr, 16'h0102);
    chk("mredir1_instr", fd_instr, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'hAAAA);
    chk("squash0_addr", imem_addr, 16'h0102);
    chk("squash0_req", {15'd0, imem_req}, 16'd1);
    chk("squash0_instr", fd_instr, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h789A);
    chk("squash1_addr", imem_addr, 16'h0102);
    chk("squash1_instr", fd_instr, 16'h0000);
    chk("squash1_pc", fd_pc, 16'h0042);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
    chk("post_squash_addr", imem_addr, 16'h0040);
    chk("post_squash_instr", fd_instr, 16'h1111);
    chk("post_squash_pc", fd_pc, 16'h0042);
    tick();

    drive(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h3333);
    chk("wrap_redir_instr", fd_instr, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    chk("wrap_pc", fd_pc, 16'h0000);
    tick();

    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000);
    chk("hlt_addr", imem_addr, 16'h0000);
    chk("hlt_instr", fd_instr, 16'hF000);
    chk("hlt_pc", fd_pc, 16'h0002);
    chk("hlt_halted", {15'd0, halted}, 16'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk("halt0_halted", {15'd0, halted}, 16'd1);
    chk("halt0_req", {15'd0, imem_req}, 16'd0);
    chk("halt0_instr", fd_instr, 16'h0000);
    chk("halt0_en", {15'd0, fd_enable}, 16'd1);
    tick();
    drive(1'b1, 1'b1, 16'h0300, 1'b1, 16'h1234);
    chk("halt1_halted", {15'd0, halted}, 16'd1);
    chk("halt1_en", {15'd0, fd_enable}, 16'd0);
    tick();
    drive(1'b0, 1'b1, 16'h0300, 1'b1, 16'h1234);
    chk("halt2_halted", {15'd0, halted}, 16'd1);
    chk("halt2_instr", fd_instr, 16'h0000);
    tick();

    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    chk("async_rst_halted", {15'd0, halted}, 16'd0);
    chk("async_rst_req", {15'd0, imem_req}, 16'd0);
    chk("async_rst_en", {15'd0, fd_enable}, 16'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("rerun_addr", imem_addr, 16'h0000);
    chk("rerun_req", {15'd0, imem_req}, 16'd1);
    chk("rerun_pc", fd_pc, 16'h0002);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
